// File: rtl/ppi8255.sv
// ppi8255: 8255-style PPI with control word, BSR on port C and group A mode-1 strobed handshake
//   clk, reset_n (async active-low); CPU bus: clken, cs, rnw, addr[1:0], din[7:0], dout[7:0] (combinational)
//   ports: p{a,b,c}_in pin inputs, p{a,b,c}_out output latches, p{a,b,c}_oe per-bit enables; intr_a = INTRA
module ppi8255 #(
  parameter logic [7:0] RESET_CTRL  = 8'h9B,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clken,
  input  logic       cs,
  input  logic       rnw,
  input  logic [1:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] pa_in,
  input  logic [7:0] pb_in,
  input  logic [7:0] pc_in,
  output logic [7:0] pa_out,
  output logic [7:0] pb_out,
  output logic [7:0] pc_out,
  output logic [7:0] pa_oe,
  output logic [7:0] pb_oe,
  output logic [7:0] pc_oe,
  output logic       intr_a
);
  // cfg keeps only the live control bits: {mode_a[1:0], pa_in, pcu_in, pb_in, pcl_in}
  localparam logic [5:0] RESET_CFG = {RESET_CTRL[6:3], RESET_CTRL[1:0]};
  logic [5:0] cfg_q, cfg_d;
  logic [7:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pal_q, pal_d, pc_rd, pa_rd;
  logic ibf_q, ibf_d, intr_q, intr_d, inte_q, inte_d, obf_n_q, obf_n_d;
  // chain index SYNC_STAGES-1 is the synced pin, index SYNC_STAGES its previous value
  logic [SYNC_STAGES:0] stb_q, stb_d, ack_q, ack_d;
  logic wr, rd, m1, a_in, stb_s, ack_s, stb_fall, ack_fall, ack_rise;
  logic wr_pa, rd_pa, wr_ctl, wr_bsr, bsr_inte, m1_out_wr;
  assign wr        = clken & cs & ~rnw;
  assign rd        = clken & cs & rnw;
  assign m1        = |cfg_q[5:4];
  assign a_in      = cfg_q[3];
  assign stb_s     = stb_q[SYNC_STAGES-1];
  assign ack_s     = ack_q[SYNC_STAGES-1];
  assign stb_fall  = m1 & a_in & stb_q[SYNC_STAGES] & ~stb_s;
  assign ack_fall  = m1 & ~a_in & ack_q[SYNC_STAGES] & ~ack_s;
  assign ack_rise  = m1 & ~a_in & ~ack_q[SYNC_STAGES] & ack_s;
  assign wr_pa     = wr & (addr == 2'd0);
  assign rd_pa     = rd & (addr == 2'd0);
  assign wr_ctl    = wr & (addr == 2'd3) & din[7];
  assign wr_bsr    = wr & (addr == 2'd3) & ~din[7];
  assign bsr_inte  = m1 & (a_in ? din[3:1] == 3'd4 : din[3:1] == 3'd6);
  assign m1_out_wr = wr_pa & m1 & ~a_in;
  assign intr_a    = m1 & (a_in ? inte_q & ibf_q & stb_s : intr_q);
  assign pa_oe     = a_in ? 8'h00 : 8'hFF;
  assign pb_oe     = cfg_q[1] ? 8'h00 : 8'hFF;
  assign pa_out    = pa_q;
  assign pb_out    = pb_q;
  always_comb begin
    stb_d   = {stb_q[SYNC_STAGES-1:0], pc_in[4]};
    ack_d   = {ack_q[SYNC_STAGES-1:0], pc_in[6]};
    cfg_d   = cfg_q;
    pa_d    = wr_pa ? din : pa_q;
    pb_d    = (wr && addr == 2'd1) ? din : pb_q;
    pc_d    = (wr && addr == 2'd2) ? din : pc_q;
    if (wr_bsr && !bsr_inte) pc_d[din[3:1]] = din[0];
    pal_d   = stb_fall ? pa_in : pal_q;
    ibf_d   = stb_fall | (ibf_q & ~(rd_pa & m1 & a_in));
    inte_d  = (wr_bsr && bsr_inte) ? din[0] : inte_q;
    obf_n_d = m1_out_wr ? 1'b0 : ack_fall ? 1'b1 : obf_n_q;
    intr_d  = m1_out_wr ? 1'b0 : (ack_rise && obf_n_q && inte_q) ? 1'b1 : intr_q;
    if (wr_ctl) begin
      cfg_d   = {din[6:3], din[1:0]};
      pa_d    = 8'h00;
      pb_d    = 8'h00;
      pc_d    = 8'h00;
      ibf_d   = 1'b0;
      intr_d  = 1'b0;
      inte_d  = 1'b0;
      obf_n_d = 1'b1;
    end
  end
  always_comb begin
    pc_oe  = {{4{~cfg_q[2]}}, {4{~cfg_q[0]}}};
    pc_out = pc_q;
    if (m1) begin
      pc_oe[3]  = 1'b1;
      pc_out[3] = intr_a;
      if (a_in) begin
        pc_oe[4]  = 1'b0;
        pc_out[4] = 1'b0;
        pc_oe[5]  = 1'b1;
        pc_out[5] = ibf_q;
      end else begin
        pc_oe[6]  = 1'b0;
        pc_out[6] = 1'b0;
        pc_oe[7]  = 1'b1;
        pc_out[7] = obf_n_q;
      end
    end
    pc_rd = (pc_in & ~pc_oe) | (pc_out & pc_oe);
    if (m1 && a_in) pc_rd[4] = stb_s;
    if (m1 && !a_in) pc_rd[6] = ack_s;
    pa_rd = (m1 && a_in) ? pal_q : (pa_in & ~pa_oe) | (pa_q & pa_oe);
    dout  = addr == 2'd0 ? pa_rd :
            addr == 2'd1 ? (pb_in & ~pb_oe) | (pb_q & pb_oe) :
            addr == 2'd2 ? pc_rd : 8'h00;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_q   <= RESET_CFG;
      pa_q    <= '0;
      pb_q    <= '0;
      pc_q    <= '0;
      pal_q   <= '0;
      ibf_q   <= 1'b0;
      intr_q  <= 1'b0;
      inte_q  <= 1'b0;
      obf_n_q <= 1'b1;
      stb_q   <= '1;
      ack_q   <= '1;
    end else begin
      cfg_q   <= cfg_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pc_q    <= pc_d;
      pal_q   <= pal_d;
      ibf_q   <= ibf_d;
      intr_q  <= intr_d;
      inte_q  <= inte_d;
      obf_n_q <= obf_n_d;
      stb_q   <= stb_d;
      ack_q   <= ack_d;
    end
  end
endmodule

// File: tb/tb_ppi8255.sv
// tb_ppi8255: directed self-checking bench for ppi8255
module tb_ppi8255;
  logic clk = 0, reset_n = 0, clken = 0, cs = 0, rnw = 1;
  logic [1:0] addr = 0;
  logic [7:0] din = 0, dout, pa_in = 0, pb_in = 8'h5A, pc_in = 8'hFF;
  logic [7:0] pa_out, pb_out, pc_out, pa_oe, pb_oe, pc_oe;
  logic intr_a;
  int tests = 0, fails = 0;
  ppi8255 dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cs(cs), .rnw(rnw), .addr(addr),
    .din(din), .dout(dout), .pa_in(pa_in), .pb_in(pb_in), .pc_in(pc_in),
    .pa_out(pa_out), .pb_out(pb_out), .pc_out(pc_out),
    .pa_oe(pa_oe), .pb_oe(pb_oe), .pc_oe(pc_oe), .intr_a(intr_a)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1; clken = 1; rnw = 0; addr = a; din = d;
    @(negedge clk);
    cs = 0; clken = 0; rnw = 1;
  endtask
  task automatic rd(input logic [1:0] a, input string tag, input logic [7:0] e);
    cs = 1; clken = 1; rnw = 1; addr = a;
    #1 chk(tag, dout, e);
    @(negedge clk);
    cs = 0; clken = 0;
  endtask
  initial begin
    tick(3);
    chk("rst_pa_oe", pa_oe, 8'h00);
    chk("rst_pc_oe", pc_oe, 8'h00);
    reset_n = 1;
    tick(1);
    chk("rst_pb_oe", pb_oe, 8'h00);
    chk("rst_intr", {7'd0, intr_a}, 8'h00);
    chk("rst_pc_out", pc_out, 8'h00);
    rd(2'd1, "rd_pb_in", 8'h5A);
    wr(2'd3, 8'h80);
    wr(2'd0, 8'h3C);
    chk("m0_pa_oe", pa_oe, 8'hFF);
    chk("m0_pa_out", pa_out, 8'h3C);
    chk("m0_pc_oe", pc_oe, 8'hFF);
    rd(2'd0, "m0_rd_pa", 8'h3C);
    rd(2'd3, "rd_ctl", 8'h00);
    wr(2'd3, 8'h80);
    chk("ctl_clr_pa", pa_out, 8'h00);
    wr(2'd3, 8'h0F);
    chk("bsr_set7", pc_out, 8'h80);
    wr(2'd3, 8'h0C);
    chk("bsr_clr6", pc_out, 8'h80);
    wr(2'd3, 8'h0E);
    chk("bsr_clr7", pc_out, 8'h00);
    wr(2'd3, 8'hB0);
    wr(2'd3, 8'h09);
    chk("m1i_pa_oe", pa_oe, 8'h00);
    chk("m1i_pc_oe", pc_oe, 8'hEF);
    chk("m1i_pc_out0", pc_out, 8'h00);
    pa_in = 8'hA5;
    pc_in[4] = 0;
    tick(2);
    chk("m1i_ibf_early", pc_out, 8'h00);
    tick(1);
    chk("m1i_ibf_set", pc_out, 8'h20);
    chk("m1i_intr_lo", {7'd0, intr_a}, 8'h00);
    tick(1);
    pc_in[4] = 1;
    pa_in = 8'h00;
    tick(1);
    chk("m1i_intr_wait", {7'd0, intr_a}, 8'h00);
    tick(1);
    chk("m1i_intr_set", {7'd0, intr_a}, 8'h01);
    chk("m1i_pc_out", pc_out, 8'h28);
    rd(2'd2, "m1i_rd_pc", 8'h38);
    rd(2'd0, "m1i_rd_pa", 8'hA5);
    chk("m1i_ibf_clr", pc_out, 8'h00);
    chk("m1i_intr_clr", {7'd0, intr_a}, 8'h00);
    pa_in = 8'hC3;
    pc_in[4] = 0;
    tick(2);
    rd(2'd0, "sim_rd_pa", 8'hA5);
    chk("sim_ibf_kept", pc_out, 8'h20);
    wr(2'd3, 8'hB0);
    chk("abort_pc_out", pc_out, 8'h00);
    chk("abort_intr", {7'd0, intr_a}, 8'h00);
    tick(3);
    chk("abort_no_spur", pc_out, 8'h00);
    pc_in[4] = 1;
    tick(3);
    pc_in[4] = 0;
    tick(4);
    pc_in[4] = 1;
    tick(3);
    chk("abort_inte_clr", pc_out, 8'h20);
    rd(2'd0, "sim_latched", 8'hC3);
    wr(2'd3, 8'hA0);
    wr(2'd3, 8'h0D);
    chk("m1o_pa_oe", pa_oe, 8'hFF);
    chk("m1o_pc_oe", pc_oe, 8'hBF);
    chk("m1o_pc_out0", pc_out, 8'h80);
    wr(2'd0, 8'h77);
    chk("m1o_pa_out", pa_out, 8'h77);
    chk("m1o_obf_lo", pc_out, 8'h00);
    pc_in[6] = 0;
    tick(2);
    chk("m1o_obf_wait", pc_out, 8'h00);
    tick(1);
    chk("m1o_obf_hi", pc_out, 8'h80);
    pc_in[6] = 1;
    tick(2);
    chk("m1o_intr_wait", {7'd0, intr_a}, 8'h00);
    tick(1);
    chk("m1o_intr_set", {7'd0, intr_a}, 8'h01);
    chk("m1o_pc_out", pc_out, 8'h88);
    wr(2'd0, 8'h78);
    chk("m1o_intr_clr", {7'd0, intr_a}, 8'h00);
    chk("m1o_obf_lo2", pc_out, 8'h00);
    pc_in[6] = 0;
    tick(3);
    chk("m1o_obf_hi2", pc_out, 8'h80);
    pc_in[6] = 1;
    tick(3);
    chk("m1o_intr2", {7'd0, intr_a}, 8'h01);
    pc_in[6] = 0;
    tick(2);
    wr(2'd0, 8'h99);
    chk("sim_wr_wins", pc_out, 8'h00);
    pc_in[6] = 1;
    tick(3);
    chk("rise_obf_lo", {7'd0, intr_a}, 8'h00);
    pc_in[6] = 0;
    tick(3);
    pc_in[6] = 1;
    tick(3);
    chk("pre_rst_intr", {7'd0, intr_a}, 8'h01);
    #2 reset_n = 0;
    #1;
    chk("arst_intr", {7'd0, intr_a}, 8'h00);
    chk("arst_pa_out", pa_out, 8'h00);
    chk("arst_pc_out", pc_out, 8'h00);
    chk("arst_pa_oe", pa_oe, 8'h00);
    tick(1);
    reset_n = 1;
    tick(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
